// File: rtl/fft_frame_loader_if.sv
// Sample-stream and frame-presentation bundle between a streaming source, the frame loader and the FFT.
// With FFT_FRAME_LOADER_DROP_EN defined the bundle also carries the dropped-sample counter.
interface fft_frame_loader_if #(
   parameter int SIZE = 16,
   parameter int RN   = 16
);
   logic                          s_valid;
   logic                          s_ready;
   logic [1:0][RN-1:0]            s_data;
   logic                          swap;
   logic [SIZE-1:0][1:0][RN-1:0]  frame;
   logic                          frame_valid;
   logic                          frame_swapped;
   logic [7:0]                    frame_cnt;
`ifdef FFT_FRAME_LOADER_DROP_EN
   logic [15:0]                   drop_cnt;
`endif

   modport slave (
      input  s_valid, s_data, swap,
      output s_ready, frame, frame_valid, frame_swapped, frame_cnt
`ifdef FFT_FRAME_LOADER_DROP_EN
      , output drop_cnt
`endif
   );

   modport master (
      output s_valid, s_data, swap,
      input  s_ready, frame, frame_valid, frame_swapped, frame_cnt
`ifdef FFT_FRAME_LOADER_DROP_EN
      , input drop_cnt
`endif
   );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong frame store that turns a one-sample-per-cycle stream into a stable parallel FFT input frame.
// Optional FFT_FRAME_LOADER_DROP_EN: never backpressure; samples arriving on a full bank are counted and dropped.
module fft_frame_loader #(
   parameter int SIZE = 16,
   parameter int RN   = 16
) (
   input  logic               clk,
   input  logic               n_reset,
   fft_frame_loader_if.slave  bus
);
   localparam int IW = $clog2(SIZE);

   typedef logic [SIZE-1:0][1:0][RN-1:0] bank_t;

   bank_t           bank0_q, bank0_d;
   bank_t           bank1_q, bank1_d;
   logic            disp_q, disp_d;
   logic [IW-1:0]   wrIdx_q, wrIdx_d;
   logic            fillFull_q, fillFull_d;
   logic            frameValid_q, frameValid_d;
   logic            frameSwapped_q, frameSwapped_d;
   logic [7:0]      frameCnt_q, frameCnt_d;
   logic            writeEn;
   logic            swapTake;

   // A full bank is never written, so swap and write are mutually exclusive in any cycle.
   assign writeEn  = bus.s_valid & ~fillFull_q;
   assign swapTake = bus.swap & fillFull_q;

   always_comb begin
      bank0_d        = bank0_q;
      bank1_d        = bank1_q;
      disp_d         = disp_q;
      wrIdx_d        = wrIdx_q;
      fillFull_d     = fillFull_q;
      frameValid_d   = frameValid_q;
      frameCnt_d     = frameCnt_q;
      frameSwapped_d = swapTake;
      if (writeEn) begin
         if (disp_q) begin
            bank0_d[wrIdx_q] = bus.s_data;
         end else begin
            bank1_d[wrIdx_q] = bus.s_data;
         end
         wrIdx_d = wrIdx_q + IW'(1);
         if (wrIdx_q == IW'(SIZE - 1)) begin
            fillFull_d = 1'b1;
         end
      end
      if (swapTake) begin
         disp_d       = ~disp_q;
         fillFull_d   = 1'b0;
         frameValid_d = 1'b1;
         frameCnt_d   = frameCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bank0_q        <= '0;
         bank1_q        <= '0;
         disp_q         <= 1'b0;
         wrIdx_q        <= '0;
         fillFull_q     <= 1'b0;
         frameValid_q   <= 1'b0;
         frameSwapped_q <= 1'b0;
         frameCnt_q     <= '0;
      end else begin
         bank0_q        <= bank0_d;
         bank1_q        <= bank1_d;
         disp_q         <= disp_d;
         wrIdx_q        <= wrIdx_d;
         fillFull_q     <= fillFull_d;
         frameValid_q   <= frameValid_d;
         frameSwapped_q <= frameSwapped_d;
         frameCnt_q     <= frameCnt_d;
      end
   end

`ifdef FFT_FRAME_LOADER_DROP_EN
   logic [15:0] dropCnt_q, dropCnt_d;

   always_comb begin
      dropCnt_d = dropCnt_q;
      if (bus.s_valid && fillFull_q && (dropCnt_q != 16'hFFFF)) begin
         dropCnt_d = dropCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         dropCnt_q <= '0;
      end else begin
         dropCnt_q <= dropCnt_d;
      end
   end

   assign bus.s_ready  = 1'b1;
   assign bus.drop_cnt = dropCnt_q;
`else
   assign bus.s_ready  = ~fillFull_q;
`endif

   assign bus.frame         = disp_q ? bank1_q : bank0_q;
   assign bus.frame_valid   = frameValid_q;
   assign bus.frame_swapped = frameSwapped_q;
   assign bus.frame_cnt     = frameCnt_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader (SIZE=4): directed vector table, stream/reset sequences and random traffic
// against a sample-count based reference model. Honours FFT_FRAME_LOADER_DROP_EN when defined.
module tb_fft_frame_loader;
   localparam int SIZE = 4;
   localparam int RN   = 16;
   localparam int FW   = SIZE * 2 * RN;
`ifdef FFT_FRAME_LOADER_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   typedef logic [SIZE-1:0][1:0][RN-1:0] frame_t;

   typedef struct {
      bit v;
      int re;
      int im;
      bit sw;
      bit expReady;
      bit expValid;
      bit expSwp;
      int expCnt;
   } vec_t;

   logic clk;
   logic n_reset;

   fft_frame_loader_if #(.SIZE(SIZE), .RN(RN)) busIf ();

   fft_frame_loader #(.SIZE(SIZE), .RN(RN)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [1:0][RN-1:0] mFill [SIZE];
   frame_t mDisp;
   int     mCount;
   bit     mValid;
   bit     mSwapped;
   int     mCnt;
   int     mDrop;
   bit     lastAcc;

   task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic frame_t buildFrame(input int base);
      frame_t f;
      for (int i = 0; i < SIZE; i++) begin
         f[i][0] = RN'(base + i);
         f[i][1] = RN'(-(base + i));
      end
      return f;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < SIZE; i++) mFill[i] = '0;
      mDisp    = '0;
      mCount   = 0;
      mValid   = 1'b0;
      mSwapped = 1'b0;
      mCnt     = 0;
      mDrop    = 0;
      lastAcc  = 1'b0;
   endtask

   // One clock: drive inputs, advance the model by the same clock, leave time at posedge+1.
   task automatic applyStimulus(input bit v, input int re, input int im, input bit sw);
      bit acc, tk, drp;
      busIf.s_valid   = v;
      busIf.s_data[0] = RN'(re);
      busIf.s_data[1] = RN'(im);
      busIf.swap      = sw;
      acc = v && (mCount < SIZE);
      tk  = sw && (mCount == SIZE);
      drp = DROP_EN && v && (mCount == SIZE);
      @(posedge clk);
      #1;
      if (acc) begin
         mFill[mCount][0] = RN'(re);
         mFill[mCount][1] = RN'(im);
         mCount++;
      end
      if (tk) begin
         for (int i = 0; i < SIZE; i++) mDisp[i] = mFill[i];
         mCount = 0;
         mValid = 1'b1;
         mCnt   = (mCnt + 1) % 256;
      end
      mSwapped = tk;
      if (drp && mDrop < 65535) mDrop++;
      lastAcc = acc;
   endtask

   task automatic compareModel(input string tag);
      checkOutput({tag, ".s_ready"}, FW'(busIf.s_ready), FW'(DROP_EN ? 1'b1 : (mCount < SIZE)));
      checkOutput({tag, ".frame"}, FW'(busIf.frame), FW'(mDisp));
      checkOutput({tag, ".frame_valid"}, FW'(busIf.frame_valid), FW'(mValid));
      checkOutput({tag, ".frame_swapped"}, FW'(busIf.frame_swapped), FW'(mSwapped));
      checkOutput({tag, ".frame_cnt"}, FW'(busIf.frame_cnt), FW'(mCnt[7:0]));
`ifdef FFT_FRAME_LOADER_DROP_EN
      checkOutput({tag, ".drop_cnt"}, FW'(busIf.drop_cnt), FW'(mDrop[15:0]));
`endif
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".s_ready"}, FW'(busIf.s_ready), FW'(1'b1));
      checkOutput({tag, ".frame"}, FW'(busIf.frame), '0);
      checkOutput({tag, ".frame_valid"}, FW'(busIf.frame_valid), FW'(1'b0));
      checkOutput({tag, ".frame_swapped"}, FW'(busIf.frame_swapped), FW'(1'b0));
      checkOutput({tag, ".frame_cnt"}, FW'(busIf.frame_cnt), FW'(8'd0));
`ifdef FFT_FRAME_LOADER_DROP_EN
      checkOutput({tag, ".drop_cnt"}, FW'(busIf.drop_cnt), FW'(16'd0));
`endif
   endtask

   task automatic doReset();
      n_reset       = 1'b0;
      busIf.s_valid = 1'b0;
      busIf.swap    = 1'b0;
      busIf.s_data  = '0;
      #3;
      modelReset();
      @(negedge clk);
      n_reset = 1'b1;
   endtask

   initial begin
      vec_t tbl [16];
      int   next;
      int   swaps;

      n_reset       = 1'b0;
      busIf.s_valid = 1'b0;
      busIf.swap    = 1'b0;
      busIf.s_data  = '0;
      modelReset();
      #2;
      checkResetState("resetHeld");
      @(negedge clk);
      n_reset = 1'b1;
      #1;
      checkResetState("resetReleased");

      // Fill, swap, partial-fill swap and coincident last-sample/swap, one row per clock.
      tbl[0]  = '{1, 1, -1, 0, 1, 0, 0, 0};
      tbl[1]  = '{1, 2, -2, 0, 1, 0, 0, 0};
      tbl[2]  = '{1, 3, -3, 0, 1, 0, 0, 0};
      tbl[3]  = '{1, 4, -4, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0,  0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0,  0, 1, 1, 1, 1, 1};
      tbl[6]  = '{0, 0,  0, 0, 1, 1, 0, 1};
      tbl[7]  = '{1, 5, -5, 0, 1, 1, 0, 1};
      tbl[8]  = '{1, 6, -6, 0, 1, 1, 0, 1};
      tbl[9]  = '{0, 0,  0, 1, 1, 1, 0, 1};
      tbl[10] = '{1, 7, -7, 0, 1, 1, 0, 1};
      tbl[11] = '{1, 8, -8, 1, 0, 1, 0, 1};
      tbl[12] = '{0, 0,  0, 0, 0, 1, 0, 1};
      tbl[13] = '{0, 0,  0, 0, 0, 1, 0, 1};
      tbl[14] = '{0, 0,  0, 0, 0, 1, 0, 1};
      tbl[15] = '{0, 0,  0, 1, 1, 1, 1, 2};

      for (int r = 0; r < 16; r++) begin
         applyStimulus(tbl[r].v, tbl[r].re, tbl[r].im, tbl[r].sw);
         checkOutput($sformatf("tbl%0d.s_ready", r), FW'(busIf.s_ready), FW'(DROP_EN ? 1'b1 : tbl[r].expReady));
         checkOutput($sformatf("tbl%0d.frame_valid", r), FW'(busIf.frame_valid), FW'(tbl[r].expValid));
         checkOutput($sformatf("tbl%0d.frame_swapped", r), FW'(busIf.frame_swapped), FW'(tbl[r].expSwp));
         checkOutput($sformatf("tbl%0d.frame_cnt", r), FW'(busIf.frame_cnt), FW'(8'(tbl[r].expCnt)));
         if (r < 5) checkOutput($sformatf("tbl%0d.frameZero", r), FW'(busIf.frame), '0);
         if (r >= 5 && r < 15) checkOutput($sformatf("tbl%0d.frame1to4", r), FW'(busIf.frame), FW'(buildFrame(1)));
         if (r == 15) checkOutput("tbl15.frame5to8", FW'(busIf.frame), FW'(buildFrame(5)));
         compareModel($sformatf("tbl%0d", r));
      end

      // Asynchronous reset in the middle of a fill with a frame on display.
      applyStimulus(1, 9, -9, 0);
      applyStimulus(1, 10, -10, 0);
      #2;
      n_reset = 1'b0;
      #1;
      checkResetState("midReset");
      modelReset();
      @(negedge clk);
      n_reset = 1'b1;
      #1;
      checkResetState("midResetReleased");

      // Continuous stream 8..15, swap offered as soon as a bank is full.
      doReset();
      next  = 8;
      swaps = 0;
      for (int c = 0; c < 40 && swaps < 2; c++) begin
         applyStimulus(next <= 15, next, -next, mCount == SIZE);
         compareModel("stream");
         if (lastAcc) next++;
         if (mSwapped) begin
            swaps++;
            checkOutput($sformatf("streamFrame%0d", swaps), FW'(busIf.frame), FW'(buildFrame(8 + 4 * (swaps - 1))));
         end
      end
      checkOutput("streamSwaps", FW'(swaps), FW'(2));
      checkOutput("streamFrameCnt", FW'(busIf.frame_cnt), FW'(8'd2));

`ifdef FFT_FRAME_LOADER_DROP_EN
      // Overflow without backpressure: extra samples are counted, not stored.
      doReset();
      for (int i = 1; i <= 4; i++) applyStimulus(1, i, -i, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 100 + i, -(100 + i), 0);
         checkOutput("dropReady", FW'(busIf.s_ready), FW'(1'b1));
      end
      checkOutput("dropCount5", FW'(busIf.drop_cnt), FW'(16'd5));
      applyStimulus(0, 0, 0, 1);
      checkOutput("dropFrame", FW'(busIf.frame), FW'(buildFrame(1)));
      compareModel("drop");
`endif

      // Random traffic against the model.
      doReset();
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom), int'($urandom), $urandom_range(0, 3) == 0);
         compareModel("rand");
      end

      busIf.s_valid = 1'b0;
      busIf.swap    = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
